// File: rtl/el2_ahbl_systick.sv
// el2_ahbl_systick: AHB-Lite slave SysTick timer (CTRL/LOAD/VAL/CALIB), zero wait states.
// Build option: define SYSTICK_CALIB_EN to report NOREF=1, SKEW=0 and CALIB_TENMS in CALIB;
// with it undefined CALIB reads as zero and CALIB_TENMS has no effect.
module el2_ahbl_systick #(
  parameter logic [23:0] CALIB_TENMS = 24'd1000000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  input  logic [23:0] SYSTICKCLKDIV,
  output logic        IRQ
);

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_LOAD  = 2'd1;
  localparam logic [1:0] REG_VAL   = 2'd2;
  localparam logic [1:0] REG_CALIB = 2'd3;

  logic        addr_accept;
  logic        dp_valid;
  logic        dp_write;
  logic        dp_word;
  logic [1:0]  dp_addr;

  logic        ctrl_enable;
  logic        ctrl_tickint;
  logic        ctrl_clksrc;
  logic        count_flag;
  logic        irq_q;
  logic [23:0] load_q;
  logic [23:0] val_q;
  logic [23:0] val_d;
  logic [23:0] presc_q;
  logic [23:0] presc_d;

  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_val;
  logic        rd_active;
  logic        rd_ctrl;
  logic        tick;
  logic        count_en;
  logic        flag_set;
  logic        flag_d;
  logic        tickint_d;
  logic [31:0] ctrl_word;
  logic [31:0] calib_word;
  logic        unused_inputs;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = irq_q;

  assign addr_accept = HSEL & HREADY & HTRANS[1];

  // Capture the accepted address phase so the next cycle can act as its data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= 1'b0;
      dp_addr  <= 2'd0;
    end else begin
      dp_valid <= addr_accept;
      dp_write <= HWRITE;
      dp_word  <= (HSIZE == 3'b010);
      dp_addr  <= HADDR[3:2];
    end
  end

  assign wr_en     = dp_valid & dp_write & dp_word;
  assign wr_ctrl   = wr_en & (dp_addr == REG_CTRL);
  assign wr_load   = wr_en & (dp_addr == REG_LOAD);
  assign wr_val    = wr_en & (dp_addr == REG_VAL);
  assign rd_active = dp_valid & ~dp_write;
  assign rd_ctrl   = rd_active & (dp_addr == REG_CTRL);

  assign tick      = ctrl_enable & (presc_q == SYSTICKCLKDIV);
  assign count_en  = ctrl_enable & (ctrl_clksrc ? tick : 1'b1);
  assign flag_set  = count_en & (val_q == 24'd1);
  assign tickint_d = wr_ctrl ? HWDATA[1] : ctrl_tickint;

  // Prescaler runs only while enabled and wraps to zero on reaching SYSTICKCLKDIV.
  always_comb begin
    presc_d = 24'd0;
    if (ctrl_enable && !tick) begin
      presc_d = presc_q + 24'd1;
    end
  end

  // Counter and flag next state: a VAL write beats counting, a fresh 1->0 set beats a read-clear.
  always_comb begin
    val_d  = val_q;
    flag_d = count_flag;
    if (wr_val) begin
      val_d  = 24'd0;
      flag_d = 1'b0;
    end else begin
      if (count_en) begin
        val_d = (val_q == 24'd0) ? load_q : (val_q - 24'd1);
      end
      flag_d = flag_set | (count_flag & ~rd_ctrl);
    end
  end

  // Architectural registers; IRQ is registered from the next-state flag so it tracks it exactly.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_enable  <= 1'b0;
      ctrl_tickint <= 1'b0;
      ctrl_clksrc  <= 1'b0;
      load_q       <= 24'd0;
      val_q        <= 24'd0;
      presc_q      <= 24'd0;
      count_flag   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable <= HWDATA[0];
        ctrl_clksrc <= HWDATA[2];
      end
      ctrl_tickint <= tickint_d;
      if (wr_load) begin
        load_q <= HWDATA[23:0];
      end
      val_q      <= val_d;
      presc_q    <= presc_d;
      count_flag <= flag_d;
      irq_q      <= flag_d & tickint_d;
    end
  end

  assign ctrl_word = {15'd0, count_flag, 13'd0, ctrl_clksrc, ctrl_tickint, ctrl_enable};

`ifdef SYSTICK_CALIB_EN
  assign calib_word = {1'b1, 1'b0, 6'd0, CALIB_TENMS};
`else
  assign calib_word = 32'h0000_0000;
`endif

  // Bus bits with no function in this slave, gathered so they are visibly intentional.
  assign unused_inputs = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:24], CALIB_TENMS};

  // Read data is driven only during a read data phase and is zero otherwise.
  always_comb begin
    HRDATA = 32'd0;
    if (rd_active) begin
      case (dp_addr)
        REG_CTRL:  HRDATA = ctrl_word;
        REG_LOAD:  HRDATA = {8'd0, load_q};
        REG_VAL:   HRDATA = {8'd0, val_q};
        REG_CALIB: HRDATA = calib_word;
        default:   HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_el2_ahbl_systick.sv
// tb_el2_ahbl_systick: directed and randomized bus traffic checked against a cycle model of SysTick.
module tb_el2_ahbl_systick;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [23:0] SYSTICKCLKDIV;
  logic        IRQ;

  el2_ahbl_systick dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HSEL          (HSEL),
    .HADDR         (HADDR),
    .HTRANS        (HTRANS),
    .HWRITE        (HWRITE),
    .HSIZE         (HSIZE),
    .HWDATA        (HWDATA),
    .HREADY        (HREADY),
    .HREADYOUT     (HREADYOUT),
    .HRDATA        (HRDATA),
    .HRESP         (HRESP),
    .SYSTICKCLKDIV (SYSTICKCLKDIV),
    .IRQ           (IRQ)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_rdata;
  logic        last_irq;
  logic [31:0] calib_exp;

  // Reference model: architectural state plus the data phase the bench has issued.
  logic        m_en, m_tickint, m_clksrc, m_flag, m_irq;
  logic [23:0] m_load, m_val, m_presc;
  logic        p_valid, p_write, p_word;
  logic [1:0]  p_addr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_tickint = 1'b0; m_clksrc = 1'b0; m_flag = 1'b0; m_irq = 1'b0;
    m_load = 24'd0; m_val = 24'd0; m_presc = 24'd0;
    p_valid = 1'b0; p_write = 1'b0; p_word = 1'b0; p_addr = 2'd0;
  endtask

  function automatic logic [31:0] model_rdata();
    if (!(p_valid && !p_write)) return 32'd0;
    case (p_addr)
      2'd0:    return (32'(m_flag) << 16) | (32'(m_clksrc) << 2) | (32'(m_tickint) << 1) | 32'(m_en);
      2'd1:    return 32'(m_load);
      2'd2:    return 32'(m_val);
      default: return calib_exp;
    endcase
  endfunction

  // One rising edge of the reference: counting rules evaluated with the bus inputs now driven.
  task automatic model_clock();
    logic        tick, step, wr, rdc, nflag;
    logic [23:0] nval;
    tick  = m_en && (m_presc == SYSTICKCLKDIV);
    step  = m_en && (m_clksrc ? tick : 1'b1);
    wr    = p_valid && p_write && p_word;
    rdc   = p_valid && !p_write && (p_addr == 2'd0);
    nval  = m_val;
    nflag = m_flag && !rdc;
    if (wr && p_addr == 2'd2) begin
      nval  = 24'd0;
      nflag = 1'b0;
    end else if (step) begin
      if (m_val == 24'd0) nval = m_load;
      else begin
        nval = m_val - 24'd1;
        if (nval == 24'd0) nflag = 1'b1;
      end
    end
    m_presc = (m_en && !tick) ? m_presc + 24'd1 : 24'd0;
    if (wr && p_addr == 2'd0) begin
      m_en = HWDATA[0]; m_tickint = HWDATA[1]; m_clksrc = HWDATA[2];
    end
    if (wr && p_addr == 2'd1) m_load = HWDATA[23:0];
    m_val  = nval;
    m_flag = nflag;
    m_irq  = m_flag && m_tickint;
    p_valid = HSEL && HREADY && HTRANS[1];
    p_write = HWRITE;
    p_word  = (HSIZE == 3'b010);
    p_addr  = HADDR[3:2];
  endtask

  // Drive one cycle: new address phase plus write data for the pending data phase.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [3:0] addr,
                               input logic write, input logic [2:0] size, input logic [31:0] wdata,
                               input logic ready);
    logic [31:0] r;
    r      = $urandom();
    HSEL   = sel;
    HTRANS = trans;
    HADDR  = {r[31:4], addr};
    HWRITE = write;
    HSIZE  = size;
    HWDATA = wdata;
    HREADY = ready;
    @(negedge HCLK);
    last_rdata = HRDATA;
    last_irq   = IRQ;
    checkOutput("hrdata", HRDATA, model_rdata());
    checkOutput("irq", {31'd0, IRQ}, {31'd0, m_irq});
    checkOutput("hreadyout_hresp", {30'd0, HREADYOUT, HRESP}, 32'd2);
    @(posedge HCLK);
    model_clock();
    #1;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] wd);
    applyStimulus(1'b1, 2'b10, a, 1'b0, 3'b010, wd, 1'b1);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] wd);
    applyStimulus(1'b1, 2'b10, a, 1'b1, 3'b010, wd, 1'b1);
  endtask

  task automatic bus_idle(input logic [31:0] wd);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 3'b010, wd, 1'b1);
  endtask

  initial begin
    logic [31:0] exp_seq [8];
    logic [31:0] wd;
    logic [3:0]  a;
    logic [2:0]  sz;
    logic        rdy;
    int          first_irq;
`ifdef SYSTICK_CALIB_EN
    calib_exp = 32'h800F_4240;
`else
    calib_exp = 32'h0000_0000;
`endif
    exp_seq = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd5};
    model_reset();
    HRESET = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = 32'd0; HREADY = 1'b1; SYSTICKCLKDIV = 24'd0;
    #1 HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    checkOutput("reset_hrdata", HRDATA, 32'd0);
    checkOutput("reset_irq", {31'd0, IRQ}, 32'd0);
    checkOutput("reset_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("reset_hresp", {31'd0, HRESP}, 32'd0);
    HRESET = 1'b0;
    $display("[TB] reset released, reading all registers");

    bus_read(4'h0, 32'd0);
    bus_read(4'h4, 32'd0);
    bus_read(4'h8, 32'd0);
    bus_read(4'hC, 32'd0);
    bus_idle(32'd0);
    checkOutput("calib_after_reset", last_rdata, calib_exp);

    // LOAD=5, CTRL=0x3 then back-to-back reads of VAL
    bus_write(4'h4, 32'd0);
    bus_write(4'h0, 32'd5);
    bus_read(4'h8, 32'd3);
    for (int i = 0; i < 8; i++) begin
      bus_read(4'h8, 32'd0);
      checkOutput("val_sequence", last_rdata, exp_seq[i]);
      if (i == 5) checkOutput("irq_before_wrap", {31'd0, last_irq}, 32'd0);
      if (i == 6) checkOutput("irq_after_wrap", {31'd0, last_irq}, 32'd1);
    end

    // CTRL read clears the flag; a 1->0 in the read cycle keeps it set
    bus_read(4'h0, 32'd0); checkOutput("val_4", last_rdata, 32'd4);
    bus_read(4'h8, 32'd0); checkOutput("ctrl_flag_set", last_rdata, 32'h0001_0003);
                           checkOutput("irq_flag_set", {31'd0, last_irq}, 32'd1);
    bus_read(4'h0, 32'd0); checkOutput("val_2", last_rdata, 32'd2);
                           checkOutput("irq_cleared", {31'd0, last_irq}, 32'd0);
    bus_read(4'h0, 32'd0); checkOutput("ctrl_flag_clear", last_rdata, 32'h0000_0003);
    bus_read(4'h8, 32'd0); checkOutput("ctrl_set_wins", last_rdata, 32'h0001_0003);
                           checkOutput("irq_set_wins", {31'd0, last_irq}, 32'd1);
    bus_read(4'h8, 32'd0); checkOutput("val_reload_5", last_rdata, 32'd5);
                           checkOutput("irq_read_clear", {31'd0, last_irq}, 32'd0);

    // VAL write while running, then a VAL write coinciding with 1->0
    bus_write(4'h8, 32'd0);    checkOutput("val_4b", last_rdata, 32'd4);
    bus_read(4'h8, 32'hABCD);
    bus_read(4'h8, 32'd0);     checkOutput("val_write_clears", last_rdata, 32'd0);
    bus_read(4'h8, 32'd0);     checkOutput("val_reload_after_write", last_rdata, 32'd5);
    bus_read(4'h8, 32'd0);
    bus_read(4'h8, 32'd0);
    bus_write(4'h8, 32'd0);    checkOutput("val_2b", last_rdata, 32'd2);
    bus_read(4'h8, 32'd1);
    bus_idle(32'd0);           checkOutput("val_write_beats_decrement", last_rdata, 32'd0);
                               checkOutput("irq_write_beats_set", {31'd0, last_irq}, 32'd0);

    // Disable, byte write to LOAD ignored, CALIB readback
    bus_write(4'h0, 32'd0);
    applyStimulus(1'b1, 2'b10, 4'h4, 1'b1, 3'b000, 32'd0, 1'b1);
    bus_read(4'h4, 32'h77);
    bus_read(4'hC, 32'd0);     checkOutput("load_byte_write_ignored", last_rdata, 32'd5);
    bus_idle(32'd0);           checkOutput("calib", last_rdata, calib_exp);

    // Prescaled source: DIV=3, LOAD=2, CTRL=0x7
    SYSTICKCLKDIV = 24'd3;
    bus_write(4'h8, 32'd0);
    bus_write(4'h4, 32'd0);
    bus_write(4'h0, 32'd2);
    bus_idle(32'd7);
    first_irq = 0;
    for (int k = 1; k <= 40; k++) begin
      bus_idle(32'd0);
      if (last_irq && first_irq == 0) first_irq = k;
    end
    checkOutput("prescaled_irq_latency", 32'(first_irq), 32'd13);
    bus_write(4'h0, 32'd0);
    bus_idle(32'd0);

    // Randomized traffic against the model
    $display("[TB] randomized phase");
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) SYSTICKCLKDIV = 24'($urandom_range(0, 3));
      wd = $urandom();
      if (p_valid && p_write && p_addr == 2'd0) wd[0] = ($urandom_range(0, 9) != 0);
      if (p_valid && p_write && p_addr == 2'd1) wd[23:0] = 24'($urandom_range(0, 6));
      sz  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 2)) : 3'b010;
      rdy = p_valid ? 1'b1 : ($urandom_range(0, 7) != 0);
      a   = {2'($urandom_range(0, 3)), 2'b00};
      applyStimulus(($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)), a,
                    1'($urandom_range(0, 1)), sz, wd, rdy);
    end

    // Reset mid-count with a LOAD write data phase pending
    bus_write(4'h8, 32'd0);
    bus_write(4'h4, 32'd0);
    bus_write(4'h0, 32'd2);
    bus_idle(32'd3);
    for (int k = 0; k < 10; k++) begin
      bus_idle(32'd0);
      if (last_irq) break;
    end
    checkOutput("irq_before_reset", {31'd0, last_irq}, 32'd1);
    bus_write(4'h4, 32'd0);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55;
    #3 HRESET = 1'b1;
    #1;
    checkOutput("async_reset_irq", {31'd0, IRQ}, 32'd0);
    checkOutput("async_reset_hrdata", HRDATA, 32'd0);
    checkOutput("async_reset_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    model_reset();
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    bus_read(4'h4, 32'd0);
    bus_read(4'h0, 32'd0);     checkOutput("load_after_reset", last_rdata, 32'd0);
    bus_read(4'h8, 32'd0);     checkOutput("ctrl_after_reset", last_rdata, 32'd0);
    bus_idle(32'd0);           checkOutput("val_after_reset", last_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
